// File: rtl/button_process_unit.sv
// Debounces a raw mechanical button and emits one registered clock pulse per press.
// Define BUTTON_AUTO_REPEAT_EN to add auto-repeat pulses while the button stays held.
module button_process_unit #(
  parameter int sim = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic ButtonIn,
  output logic ButtonOut
);

  localparam int unsigned cnt_w = 20;
  localparam logic [cnt_w-1:0] n_last = (sim != 0) ? 20'd99 : 20'd999_999;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int unsigned rpt_w = 26;
  localparam logic [rpt_w-1:0] d_last = (sim != 0) ? 26'd299 : 26'd49_999_999;
  localparam logic [rpt_w-1:0] r_last = (sim != 0) ? 26'd99  : 26'd9_999_999;
`endif

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  state_t           state;
  logic [cnt_w-1:0] cnt;
  logic             sync_ff;
  logic             sync_in;

`ifdef BUTTON_AUTO_REPEAT_EN
  logic [rpt_w-1:0] rpt_cnt;
  logic             rpt_first;
`endif

  // Synchronizer, debounce FSM and registered pulse output in one clocked process.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff   <= 1'b0;
      sync_in   <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      ButtonOut <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
`endif
    end else begin
      sync_ff   <= ButtonIn;
      sync_in   <= sync_ff;
      ButtonOut <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (sync_in) state <= PRESS_CHK;
        end
        PRESS_CHK: begin
          if (!sync_in) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == n_last) begin
            state     <= PRESSED;
            cnt       <= '0;
            ButtonOut <= 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        PRESSED: begin
          cnt <= '0;
          if (!sync_in) begin
            state <= RELEASE_CHK;
          end
`ifdef BUTTON_AUTO_REPEAT_EN
          // First repeat after D held clocks, then one every R clocks.
          else if ((rpt_first && rpt_cnt == d_last) || (!rpt_first && rpt_cnt == r_last)) begin
            ButtonOut <= 1'b1;
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
          end else begin
            rpt_cnt <= rpt_cnt + 26'd1;
          end
`endif
        end
        RELEASE_CHK: begin
          if (sync_in) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == n_last) begin
            state <= IDLE;
            cnt   <= '0;
`ifdef BUTTON_AUTO_REPEAT_EN
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_process_unit.sv
// Directed bench for button_process_unit (sim=1) with a run-length debounce model.
module tb_button_process_unit;

  localparam int unsigned N = 100;

  logic clk = 1'b0;
  logic reset;
  logic ButtonIn;
  logic ButtonOut;

  always #5 clk = ~clk;

  button_process_unit #(.sim(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .ButtonIn (ButtonIn),
    .ButtonOut(ButtonOut)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int pulse_cnt   = 0;
  int last_pulse  = -1;
  int mark        = 0;

  // Model: level seen two edges late; debounced level flips after N+1 consecutive opposing samples.
  bit m_valid = 1'b0;
  bit m_s1, m_s2, m_db, m_exp, m_sval;
  int m_run;

  task automatic check_bit(input string name, input logic got, input logic want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0b want %0b", name, cyc, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_db = 1'b0; m_run = 0; m_exp = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_sval = m_s2;
      m_s2   = m_s1;
      m_s1   = ButtonIn;
      m_exp  = 1'b0;
      if (m_sval != m_db) begin
        m_run++;
        if (m_run == N + 1) begin
          m_db  = m_sval;
          m_run = 0;
          m_exp = m_sval;
        end
      end else begin
        m_run = 0;
      end
      if (m_exp) begin
        pulse_cnt++;
        last_pulse = cyc;
      end
    end
    #1;
    if (m_valid) check_bit("ButtonOut", ButtonOut, m_exp);
  end

  task automatic drive(input logic v, input int n);
    ButtonIn = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    ButtonIn = 1'b0;
    #11 reset = 1'b0;
    @(negedge clk);

    // Idle input never pulses.
    drive(1'b0, 1000);
    check_int("idle_pulses", pulse_cnt, 0);

    // Press bounce then stable press.
    for (int i = 0; i < 25; i++) begin
      drive(1'b1, 5);
      drive(1'b0, 5);
    end
    check_int("bounce_press_pulses", pulse_cnt, 0);
    mark = cyc;
    drive(1'b1, 900);
    check_int("press1_latency", last_pulse, mark + 103);
    check_int("press1_pulses", pulse_cnt, 1);

    // Release bounce then stable release.
    for (int i = 0; i < 25; i++) begin
      drive(1'b0, 5);
      drive(1'b1, 5);
    end
    drive(1'b0, 1200);
    check_int("release_pulses", pulse_cnt, 1);

    // Second press with a short glitch while held.
    mark = cyc;
    drive(1'b1, 150);
    check_int("press2_latency", last_pulse, mark + 103);
    drive(1'b0, 3);
    drive(1'b1, 300);
    drive(1'b0, 200);
    check_int("two_press_total", pulse_cnt, 2);

    // Reset mid-count with button held forces a full re-debounce.
    mark = cyc;
    drive(1'b1, 53);
    check_int("pre_reset_pulses", pulse_cnt, 2);
    reset = 1'b1;
    drive(1'b1, 1);
    reset = 1'b0;
    mark = cyc;
    drive(1'b1, 200);
    check_int("post_reset_latency", last_pulse, mark + 103);
    check_int("post_reset_pulses", pulse_cnt, 3);
    drive(1'b0, 200);
    check_int("final_pulses", pulse_cnt, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
